// File: rtl/dh_link_pkg.sv
// dh_link_pkg: shared pause states and bus widths for the two-board link
package dh_link_pkg;
  localparam int SCORE_W = 4;
  localparam int LINK_W = 6;
  typedef enum logic [1:0] {RUN, PAUSED, RESUME} pause_state_t;
  typedef logic [LINK_W-1:0] link_bus_t;
endpackage

// File: rtl/player_link_ctl_if.sv
// player_link_ctl_if: game-side and pin-side signals of the board link
interface player_link_ctl_if;
  import dh_link_pkg::*;
  logic local_pause;
  logic local_reload;
  logic [SCORE_W-1:0] local_score;
  logic player2_pause_raw;
  logic player2_reload_raw;
  logic [SCORE_W-1:0] player2_score_raw;
  logic player1_pause;
  logic player1_reload;
  logic [SCORE_W-1:0] player1_score;
  logic [SCORE_W-1:0] remote_score;
  logic remote_reload;
  logic game_paused;
  modport master (
    output local_pause, local_reload, local_score,
    output player2_pause_raw, player2_reload_raw, player2_score_raw,
    input player1_pause, player1_reload, player1_score,
    input remote_score, remote_reload, game_paused
  );
  modport slave (
    input local_pause, local_reload, local_score,
    input player2_pause_raw, player2_reload_raw, player2_score_raw,
    output player1_pause, player1_reload, player1_score,
    output remote_score, remote_reload, game_paused
  );
endinterface

// File: rtl/link_input_filter.sv
// link_input_filter: synchronise a raw bus and accept a value only once it has held steady
module link_input_filter #(
  parameter int WIDTH = 1,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 650000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0] cnt_q;
  // synchroniser chain, stability counter (saturating) and accepted value
  always_ff @(posedge clk)
    if (rst) begin
      sync_q <= '0;
      sample_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      sample_q <= sync_q[SYNC_STAGES-1];
      cnt_q <= (sync_q[SYNC_STAGES-1] != sample_q) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
      if (cnt_q == LAST) q_q <= sample_q;
    end
  assign q_o = q_q;
endmodule

// File: rtl/player_link_ctl.sv
// player_link_ctl: filters the remote link bus, drives the local one and runs the shared pause FSM
module player_link_ctl
  import dh_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 650000,
  parameter int PULSE_CYCLES = 1300000,
  parameter int RESUME_CYCLES = 65000000
) (
  input logic clk,
  input logic rst,
  player_link_ctl_if.slave link
);
  localparam int PW = $clog2(PULSE_CYCLES) + 1;
  localparam int RW = $clog2(RESUME_CYCLES) + 1;
  logic [SCORE_W-1:0] score_f;
  logic pause_f;
  logic reload_f;
  logic reload_f_q;
  logic pause_any;
  logic [PW-1:0] pulse_q;
  logic [PW-1:0] pulse_d;
  logic [RW-1:0] resume_q;
  pause_state_t state_q;
  logic game_paused_q;
  logic p1_pause_q;
  logic [SCORE_W-1:0] p1_score_q;
  link_input_filter #(.WIDTH(SCORE_W), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_score (
    .clk(clk), .rst(rst), .d_i(link.player2_score_raw), .q_o(score_f)
  );
  link_input_filter #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_pause (
    .clk(clk), .rst(rst), .d_i(link.player2_pause_raw), .q_o(pause_f)
  );
  link_input_filter #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_reload (
    .clk(clk), .rst(rst), .d_i(link.player2_reload_raw), .q_o(reload_f)
  );
  assign pause_any = link.local_pause | pause_f;
  // a new local reload restarts the stretch, otherwise count down to zero
  always_comb pulse_d = link.local_reload ? PW'(PULSE_CYCLES) : pulse_q - PW'(pulse_q != '0);
  // outgoing bus copies, stretch counter and filtered-reload history
  always_ff @(posedge clk)
    if (rst) begin
      p1_pause_q <= 1'b0;
      p1_score_q <= '0;
      pulse_q <= '0;
      reload_f_q <= 1'b0;
    end else begin
      p1_pause_q <= link.local_pause;
      p1_score_q <= link.local_score;
      pulse_q <= pulse_d;
      reload_f_q <= reload_f;
    end
  // shared pause/resume sequencing; game_paused tracks the state being entered
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= RUN;
      resume_q <= '0;
      game_paused_q <= 1'b0;
    end else
      case (state_q)
        RUN: if (pause_any) begin
          state_q <= PAUSED;
          game_paused_q <= 1'b1;
        end
        PAUSED: if (!pause_any) begin
          state_q <= RESUME;
          resume_q <= '0;
        end
        RESUME: if (pause_any) state_q <= PAUSED;
          else if (resume_q == RW'(RESUME_CYCLES - 1)) begin
            state_q <= RUN;
            game_paused_q <= 1'b0;
          end else resume_q <= resume_q + RW'(1);
        default: begin
          state_q <= RUN;
          game_paused_q <= 1'b0;
        end
      endcase
  assign link.player1_pause = p1_pause_q;
  assign link.player1_score = p1_score_q;
  assign link.player1_reload = pulse_q != '0;
  assign link.remote_score = score_f;
  assign link.remote_reload = reload_f & ~reload_f_q;
  assign link.game_paused = game_paused_q;
endmodule
